bist_stim_misr: RTL and testbench



---
 rtl/bist_pkg.sv | 26 ++
 rtl/galois_lfsr.sv | 32 +++
 rtl/bist_stim_misr.sv | 113 +++++++++++
 tb/tb_bist_stim_misr.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared types and helpers for the BIST stimulus/compaction engine.
// galois_step advances a Galois register of width w (w <= 64) by one shift.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [40:0] LFSR41_POLY = 41'h9;       // x^41 + x^3 + 1
  localparam logic [20:0] MISR21_POLY = 21'h5;       // x^21 + x^2 + 1

  function automatic logic [63:0] galois_step(input logic [63:0] state,
                                              input logic [63:0] poly,
                                              input int unsigned w);
    logic [63:0] mask;
    logic [63:0] shifted;
    logic        msb;
    mask    = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    msb     = |((state >> (w - 1)) & 64'd1);
    shifted = (state << 1) & mask;
    return msb ? (shifted ^ (poly & mask)) : shifted;
  endfunction

endpackage

// File: rtl/galois_lfsr.sv
// Galois shift register with synchronous load and a parallel XOR input,
// used both as the pattern LFSR (xor_in tied 0) and as the MISR.
module galois_lfsr
  import bist_pkg::*;
#(
  parameter int unsigned     W    = 41,
  parameter logic [W-1:0]    POLY = W'(LFSR41_POLY)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] xor_in,
  output logic [W-1:0] q
);

  logic [W-1:0] nxt;

  assign nxt = W'(galois_step(64'(q), 64'(POLY), W)) ^ xor_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/bist_stim_misr.sv
// BIST engine: LFSR patterns drive the CUT, MISR compacts its responses,
// final signature compared with golden_sig. Optional abort input: BIST_ABORT_EN.
module bist_stim_misr
  import bist_pkg::*;
#(
  parameter int unsigned       IN_W      = 41,
  parameter int unsigned       OUT_W     = 21,
  parameter int unsigned       PAT_CNT   = 1024,
  parameter logic [IN_W-1:0]   LFSR_SEED = IN_W'(1),
  parameter logic [IN_W-1:0]   LFSR_POLY = IN_W'(LFSR41_POLY),
  parameter logic [OUT_W-1:0]  MISR_POLY = OUT_W'(MISR21_POLY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OUT_W-1:0] golden_sig,
  output logic [IN_W-1:0]  cut_in,
  input  logic [OUT_W-1:0] cut_out,
`ifdef BIST_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] signature
);

  localparam int unsigned      CNT_W    = $clog2(PAT_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAT_CNT - 1);
  // An all-zero seed would lock the LFSR at zero.
  localparam logic [IN_W-1:0]  SEED_EFF = (LFSR_SEED == '0) ? IN_W'(1) : LFSR_SEED;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             abort_i;
  logic             accept;
  logic             advance;
  logic [OUT_W-1:0] misr_next;

`ifdef BIST_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  assign accept    = start && (state != S_RUN);
  assign advance   = (state == S_RUN) && !abort_i;
  assign misr_next = OUT_W'(galois_step(64'(signature), 64'(MISR_POLY), OUT_W)) ^ cut_out;

  galois_lfsr #(
    .W    (IN_W),
    .POLY (LFSR_POLY)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (SEED_EFF),
    .en       (advance),
    .xor_in   ('0),
    .q        (cut_in)
  );

  galois_lfsr #(
    .W    (OUT_W),
    .POLY (MISR_POLY)
  ) u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val ('0),
    .en       (advance),
    .xor_in   (cut_out),
    .q        (signature)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      pass  <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (abort_i) begin
            state <= S_IDLE;
            pass  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) begin
              state <= S_DONE;
              pass  <= (misr_next == golden_sig);
            end
          end
        end
        default: begin
          if (start) begin
            state <= S_RUN;
            cnt   <= '0;
            pass  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_bist_stim_misr.sv
// Scoreboard bench for bist_stim_misr: random CUT responses, reference model
// built from the shift/feedback rules; second instance covers PAT_CNT=1 and MSB wrap.
module tb_bist_stim_misr;

  localparam int PAT_A = 8;

  typedef struct {
    logic [40:0] pat;
    logic [20:0] sig;
  } cyc_t;

  typedef struct {
    logic [20:0] sig;
    logic        pass;
    logic [40:0] fin;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic [20:0] golden_a, golden_b;
  logic [40:0] cut_in_a, cut_in_b;
  logic [20:0] cut_out_a, cut_out_b;
  logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [20:0] sig_a, sig_b;
  logic        abort_a, abort_b;
  int          mode_a;
  logic [20:0] key_a, key_b;

  int n_checks = 0;
  int n_err    = 0;

  cyc_t cyc_q[$];
  res_t res_q[$];

  always #5 clk = ~clk;

  bist_stim_misr #(
    .IN_W(41), .OUT_W(21), .PAT_CNT(PAT_A),
    .LFSR_SEED(41'h0), .LFSR_POLY(41'h9), .MISR_POLY(21'h5)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .golden_sig(golden_a),
    .cut_in(cut_in_a), .cut_out(cut_out_a),
`ifdef BIST_ABORT_EN
    .abort(abort_a),
`endif
    .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a)
  );

  bist_stim_misr #(
    .IN_W(41), .OUT_W(21), .PAT_CNT(1),
    .LFSR_SEED(41'h100_0000_0000), .LFSR_POLY(41'h9), .MISR_POLY(21'h5)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .golden_sig(golden_b),
    .cut_in(cut_in_b), .cut_out(cut_out_b),
`ifdef BIST_ABORT_EN
    .abort(abort_b),
`endif
    .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b)
  );

  // Behavioural CUT: zero, constant one, or a keyed fold of the pattern.
  function automatic logic [20:0] cut_fn(logic [40:0] x, int mode, logic [20:0] key);
    case (mode)
      0:       return 21'h0;
      1:       return 21'h1;
      default: return x[20:0] ^ {1'b0, x[40:21]} ^ key;
    endcase
  endfunction

  // Multiply by x modulo the feedback polynomial, w-bit register.
  function automatic logic [63:0] times_x(logic [63:0] s, int w, logic [63:0] poly);
    logic [63:0] top;
    top = (s >> (w - 1)) & 64'd1;
    return ((s * 64'd2) % (64'd1 << w)) ^ (top != 0 ? poly : 64'd0);
  endfunction

  always_comb cut_out_a = cut_fn(cut_in_a, mode_a, key_a);
  always_comb cut_out_b = cut_fn(cut_in_b, 2, key_b);

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops per-cycle and end-of-run expectations as the DUT presents them.
  int   busy_cnt = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    cyc_t c;
    res_t r;
    if (!rst_n) begin
      busy_cnt  = 0;
      prev_done = 1'b0;
    end else begin
      if (busy_a) begin
        if (cyc_q.size() == 0) chk("unexpected_busy", 64'(busy_a), 64'd0);
        else begin
          c = cyc_q.pop_front();
          chk("pattern", 64'(cut_in_a), 64'(c.pat));
          chk("run_signature", 64'(sig_a), 64'(c.sig));
        end
        busy_cnt++;
      end
      if (done_a && !prev_done) begin
        if (res_q.size() == 0) chk("unexpected_done", 64'(done_a), 64'd0);
        else begin
          r = res_q.pop_front();
          chk("final_signature", 64'(sig_a), 64'(r.sig));
          chk("pass", 64'(pass_a), 64'(r.pass));
          chk("final_cut_in", 64'(cut_in_a), 64'(r.fin));
          chk("run_length", 64'(busy_cnt), 64'(PAT_A));
        end
      end
      if (!busy_a) busy_cnt = 0;
      prev_done = done_a;
    end
  end

  task automatic wait_done_a(string name);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done_a) seen = 1;
    end
    if (!seen) chk(name, 64'd0, 64'd1);
  endtask

  task automatic issue_a(int mode, logic [20:0] key, bit match, bit extra);
    logic [63:0] p, m;
    logic [20:0] flip;
    p = 64'd1;
    m = 64'd0;
    @(posedge clk); #1;
    for (int k = 0; k < PAT_A; k++) begin
      cyc_q.push_back('{pat: p[40:0], sig: m[20:0]});
      m = times_x(m, 21, 64'h5) ^ 64'(cut_fn(p[40:0], mode, key));
      p = times_x(p, 41, 64'h9);
    end
    flip = 21'($urandom_range(1, 21'h1F_FFFF));
    res_q.push_back('{sig: m[20:0], pass: match, fin: p[40:0]});
    mode_a   = mode;
    key_a    = key;
    golden_a = match ? m[20:0] : (m[20:0] ^ flip);
    start_a  = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(negedge clk);
    chk("start_done_low", 64'(done_a), 64'd0);
    chk("start_busy_high", 64'(busy_a), 64'd1);
    if (extra) begin
      repeat (2) @(posedge clk);
      #1 start_a = 1'b1;
      @(posedge clk);
      #1 start_a = 1'b0;
    end
    wait_done_a("timeout_done");
  endtask

  initial begin
    logic [20:0] sig_hold;
    logic [20:0] exp_b;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    abort_a = 1'b0; abort_b = 1'b0;
    golden_a = '0; golden_b = '0; mode_a = 0; key_a = '0; key_b = 21'h1A5C3;
    repeat (2) @(negedge clk);
    chk("reset_cut_in", 64'(cut_in_a), 64'd0);
    chk("reset_busy", 64'(busy_a), 64'd0);
    chk("reset_done", 64'(done_a), 64'd0);
    chk("reset_pass", 64'(pass_a), 64'd0);
    chk("reset_sig", 64'(sig_a), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    issue_a(0, 21'h0, 1'b1, 1'b0);
    issue_a(1, 21'h0, 1'b1, 1'b0);
    issue_a(1, 21'h0, 1'b0, 1'b0);
    issue_a(2, 21'h0F0F0, 1'b1, 1'b1);
    issue_a(2, 21'h0F0F0, 1'b1, 1'b0);

    // golden_sig must not be resampled once done
    sig_hold = sig_a;
    @(posedge clk); #1 golden_a = ~golden_a;
    repeat (3) @(negedge clk);
    chk("golden_ignored_pass", 64'(pass_a), 64'd1);
    chk("done_frozen_sig", 64'(sig_a), 64'(sig_hold));
    chk("done_held", 64'(done_a), 64'd1);

    for (int i = 0; i < 6; i++)
      issue_a($urandom_range(0, 2), 21'($urandom), 1'($urandom), 1'($urandom));

    // asynchronous reset in the middle of a run
    @(posedge clk); #1 start_a = 1'b1;
    cyc_q.push_back('{pat: 41'h1, sig: 21'h0});
    cyc_q.push_back('{pat: 41'h2, sig: 21'(cut_fn(41'h1, mode_a, key_a))});
    @(posedge clk); #1 start_a = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("midrun_rst_cut_in", 64'(cut_in_a), 64'd0);
    chk("midrun_rst_busy", 64'(busy_a), 64'd0);
    chk("midrun_rst_done", 64'(done_a), 64'd0);
    chk("midrun_rst_sig", 64'(sig_a), 64'd0);
    cyc_q.delete();
    res_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("after_rst_done", 64'(done_a), 64'd0);

`ifdef BIST_ABORT_EN
    @(posedge clk); #1 start_a = 1'b1; mode_a = 1;
    cyc_q.push_back('{pat: 41'h1, sig: 21'h0});
    cyc_q.push_back('{pat: 41'h2, sig: 21'h1});
    cyc_q.push_back('{pat: 41'h4, sig: 21'h3});
    @(posedge clk); #1 start_a = 1'b0;
    repeat (2) @(posedge clk);
    #1 abort_a = 1'b1;
    sig_hold = sig_a;
    @(posedge clk); #1 abort_a = 1'b0;
    cyc_q.delete();
    res_q.delete();
    chk("abort_busy", 64'(busy_a), 64'd0);
    chk("abort_done", 64'(done_a), 64'd0);
    chk("abort_sig_frozen", 64'(sig_a), 64'(sig_hold));
    repeat (4) @(negedge clk);
    chk("abort_done_stays", 64'(done_a), 64'd0);
    chk("abort_sig_still", 64'(sig_a), 64'(sig_hold));
    issue_a(2, 21'h12345, 1'b1, 1'b0);
`endif

    // PAT_CNT=1 with an MSB-only seed: one pattern, feedback on the advance
    exp_b = cut_fn(41'h100_0000_0000, 2, key_b);
    @(posedge clk); #1 start_b = 1'b1; golden_b = exp_b;
    @(posedge clk); #1 start_b = 1'b0;
    @(negedge clk);
    chk("b_busy", 64'(busy_b), 64'd1);
    chk("b_seed_pattern", 64'(cut_in_b), 64'h100_0000_0000);
    @(negedge clk);
    chk("b_done", 64'(done_b), 64'd1);
    chk("b_signature", 64'(sig_b), 64'(exp_b));
    chk("b_pass", 64'(pass_b), 64'd1);
    chk("b_wrap_pattern", 64'(cut_in_b), 64'h9);

    @(posedge clk); #1 start_b = 1'b1; golden_b = exp_b ^ 21'h4;
    @(posedge clk); #1 start_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("b_fail_pass", 64'(pass_b), 64'd0);
    chk("b_repeat_sig", 64'(sig_b), 64'(exp_b));

    repeat (2) @(negedge clk);
    chk("queues_drained", 64'(cyc_q.size() + res_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
